// File: rtl/dram_input_phase_calibrator.sv
// Sweeps the DQ capture DCM phase one step at a time, finds the first passing test-read window
// and parks the phase at its centre. Optional step timeout: define PHASE_CAL_TIMEOUT_EN.
module dram_input_phase_calibrator #(
   parameter int unsigned MAX_STEPS     = 255,
   parameter int unsigned SETTLE_CYCLES = 4,
   parameter int unsigned PS_TIMEOUT    = 64
) (
   input  logic       i_int_clock,
   input  logic       i_int_reset,
   input  logic       i_cal_start,
   output logic [1:0] o_ps,
   input  logic       i_ps_done,
   output logic       o_test_req,
   input  logic       i_test_ack,
   input  logic       i_test_pass,
   output logic       o_cal_busy,
   output logic       o_cal_done,
   output logic       o_cal_error,
   output logic [7:0] o_cal_phase,
   output logic [7:0] o_cal_window
);

   localparam logic [7:0]  MaxPos     = 8'(MAX_STEPS);
   localparam logic [15:0] SettleLast = 16'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

   typedef enum logic [3:0] {
      StIdle,
      StSettle,
      StTest,
      StStepDir,
      StStepReq,
      StStepWaitLow,
      StStepWaitHigh,
      StStepRel,
      StReturn,
      StDone,
      StError
   } state_t;

   state_t      r_state;
   logic        r_ps_done_meta;
   logic        r_ps_done_s;
   logic [1:0]  r_ps;
   logic        r_test_req;
   logic        r_cal_busy;
   logic        r_cal_done;
   logic        r_cal_error;
   logic [7:0]  r_cal_phase;
   logic [7:0]  r_cal_window;
   logic [7:0]  r_pos;
   logic [7:0]  r_first;
   logic [7:0]  r_last;
   logic        r_found;
   logic        r_dir;
   logic        r_returning;
   logic [15:0] r_cnt;

   logic [8:0]  w_sum;
   logic [7:0]  w_target;
   logic [7:0]  w_window;

`ifdef PHASE_CAL_TIMEOUT_EN
   localparam logic [15:0] TimeoutLast = 16'((PS_TIMEOUT > 0) ? PS_TIMEOUT - 1 : 0);
   logic [15:0] r_to_cnt;
`else
   // PS_TIMEOUT only matters when the step timeout is compiled in
   logic w_unused_timeout;
   assign w_unused_timeout = (PS_TIMEOUT != 0);
`endif

   // ps_done comes from the 125 MHz domain
   always_ff @(posedge i_int_clock or negedge i_int_reset) begin
      if (!i_int_reset) begin
         r_ps_done_meta <= 1'b0;
         r_ps_done_s    <= 1'b0;
      end else begin
         r_ps_done_meta <= i_ps_done;
         r_ps_done_s    <= r_ps_done_meta;
      end
   end

   // Centre is computed in 9 bits so first + last cannot wrap before the halving
   assign w_sum    = {1'b0, r_first} + {1'b0, r_last};
   assign w_target = r_found ? w_sum[8:1] : 8'd0;
   assign w_window = r_found ? (r_last - r_first + 8'd1) : 8'd0;

   always_ff @(posedge i_int_clock or negedge i_int_reset) begin
      if (!i_int_reset) begin
         r_state      <= StIdle;
         r_ps         <= 2'b00;
         r_test_req   <= 1'b0;
         r_cal_busy   <= 1'b0;
         r_cal_done   <= 1'b0;
         r_cal_error  <= 1'b0;
         r_cal_phase  <= 8'd0;
         r_cal_window <= 8'd0;
         r_pos        <= 8'd0;
         r_first      <= 8'd0;
         r_last       <= 8'd0;
         r_found      <= 1'b0;
         r_dir        <= 1'b0;
         r_returning  <= 1'b0;
         r_cnt        <= 16'd0;
`ifdef PHASE_CAL_TIMEOUT_EN
         r_to_cnt     <= 16'd0;
`endif
      end else begin
         unique case (r_state)
            StIdle: begin
               if (i_cal_start) begin
                  r_cal_done  <= 1'b0;
                  r_cal_error <= 1'b0;
                  r_pos       <= 8'd0;
                  r_first     <= 8'd0;
                  r_last      <= 8'd0;
                  r_found     <= 1'b0;
                  r_cnt       <= 16'd0;
                  r_cal_busy  <= 1'b1;
                  r_state     <= StSettle;
               end
            end

            StSettle: begin
               if (r_cnt >= SettleLast) begin
                  r_cnt      <= 16'd0;
                  r_test_req <= 1'b1;
                  r_state    <= StTest;
               end else begin
                  r_cnt <= r_cnt + 16'd1;
               end
            end

            StTest: begin
               if (i_test_ack) begin
                  r_test_req <= 1'b0;
                  if (i_test_pass) begin
                     if (!r_found) begin
                        r_found <= 1'b1;
                        r_first <= r_pos;
                     end
                     r_last <= r_pos;
                  end
                  // A fail after a pass closes the window; the sweep also stops at MaxPos
                  if ((!i_test_pass && r_found) || (r_pos == MaxPos)) begin
                     r_state <= StReturn;
                  end else begin
                     r_dir       <= 1'b1;
                     r_returning <= 1'b0;
                     r_ps        <= 2'b10;
                     r_state     <= StStepDir;
                  end
               end
            end

            StStepDir: begin
               r_ps    <= {r_dir, 1'b1};
               r_state <= StStepReq;
            end

            StStepReq: begin
`ifdef PHASE_CAL_TIMEOUT_EN
               r_to_cnt <= 16'd0;
`endif
               r_state  <= StStepWaitLow;
            end

            StStepWaitLow: begin
               if (!r_ps_done_s) begin
                  r_state <= StStepWaitHigh;
`ifdef PHASE_CAL_TIMEOUT_EN
               end else if (r_to_cnt >= TimeoutLast) begin
                  r_ps        <= 2'b00;
                  r_cal_phase <= r_pos;
                  r_cal_error <= 1'b1;
                  r_cal_busy  <= 1'b0;
                  r_state     <= StIdle;
`endif
               end
`ifdef PHASE_CAL_TIMEOUT_EN
               r_to_cnt <= r_to_cnt + 16'd1;
`endif
            end

            StStepWaitHigh: begin
               if (r_ps_done_s) begin
                  r_ps    <= {r_dir, 1'b0};
                  r_state <= StStepRel;
`ifdef PHASE_CAL_TIMEOUT_EN
               end else if (r_to_cnt >= TimeoutLast) begin
                  r_ps        <= 2'b00;
                  r_cal_phase <= r_pos;
                  r_cal_error <= 1'b1;
                  r_cal_busy  <= 1'b0;
                  r_state     <= StIdle;
`endif
               end
`ifdef PHASE_CAL_TIMEOUT_EN
               r_to_cnt <= r_to_cnt + 16'd1;
`endif
            end

            StStepRel: begin
               r_ps  <= 2'b00;
               r_pos <= r_dir ? (r_pos + 8'd1) : (r_pos - 8'd1);
               if (r_returning) begin
                  r_state <= StReturn;
               end else begin
                  r_cnt   <= 16'd0;
                  r_state <= StSettle;
               end
            end

            StReturn: begin
               r_cal_window <= w_window;
               if (r_pos > w_target) begin
                  r_dir       <= 1'b0;
                  r_returning <= 1'b1;
                  r_ps        <= 2'b00;
                  r_state     <= StStepDir;
               end else begin
                  r_state <= r_found ? StDone : StError;
               end
            end

            StDone: begin
               r_cal_done  <= 1'b1;
               r_cal_phase <= r_pos;
               r_cal_busy  <= 1'b0;
               r_state     <= StIdle;
            end

            StError: begin
               r_cal_error <= 1'b1;
               r_cal_phase <= r_pos;
               r_cal_busy  <= 1'b0;
               r_state     <= StIdle;
            end

            default: begin
               r_ps       <= 2'b00;
               r_test_req <= 1'b0;
               r_cal_busy <= 1'b0;
               r_state    <= StIdle;
            end
         endcase
      end
   end

   assign o_ps         = r_ps;
   assign o_test_req   = r_test_req;
   assign o_cal_busy   = r_cal_busy;
   assign o_cal_done   = r_cal_done;
   assign o_cal_error  = r_cal_error;
   assign o_cal_phase  = r_cal_phase;
   assign o_cal_window = r_cal_window;

endmodule

// File: tb/tb_dram_input_phase_calibrator.sv
// Bench for dram_input_phase_calibrator: DCM step model, test-read responder and
// a scoreboard of expected calibration results per table vector.
module tb_dram_input_phase_calibrator;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       cal_start = 1'b0;
   logic [1:0] dut_ps;
   logic       ps_done = 1'b1;
   logic       test_req;
   logic       test_ack = 1'b0;
   logic       test_pass = 1'b0;
   logic       cal_busy;
   logic       cal_done;
   logic       cal_error;
   logic [7:0] cal_phase;
   logic [7:0] cal_window;

   always #5 clk = ~clk;

   dram_input_phase_calibrator #(
      .MAX_STEPS     (40),
      .SETTLE_CYCLES (4),
      .PS_TIMEOUT    (64)
   ) dut (
      .i_int_clock  (clk),
      .i_int_reset  (rst_n),
      .i_cal_start  (cal_start),
      .o_ps         (dut_ps),
      .i_ps_done    (ps_done),
      .o_test_req   (test_req),
      .i_test_ack   (test_ack),
      .i_test_pass  (test_pass),
      .o_cal_busy   (cal_busy),
      .o_cal_done   (cal_done),
      .o_cal_error  (cal_error),
      .o_cal_phase  (cal_phase),
      .o_cal_window (cal_window)
   );

   typedef struct {
      int lo; int hi; bit stale; bit spur; bit restart;
      int phase; int window; bit done; bit error; int incs; int decs;
   } vec_t;

   typedef struct {
      int phase; int window; bit done; bit error; int incs; int decs;
   } exp_t;

   vec_t vecs[8];
   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_err = 0;

   // Stimulus controls (written only by the main initial block)
   int   win_lo = 100;
   int   win_hi = 100;
   bit   stale = 1'b0;
   bit   spur = 1'b0;
   int   hang_step = 0;
   bit   dcm_rst = 1'b0;

   // DCM model state (written only by the DCM block)
   logic ps0_q = 1'b0;
   logic ps1_q = 1'b0;
   int   dcm_cnt = 0;
   bit   dcm_hang = 1'b0;
   int   low_cnt = 10;
   int   tb_pos = 0;
   int   n_inc = 0;
   int   n_dec = 0;
   int   n_req = 0;
   int   viol = 0;
   int   ack_cnt = 0;

   wire rise = dut_ps[0] & ~ps0_q;
   wire fall = ~dut_ps[0] & ps0_q;

   // DCM: ps_done drops on a request and rises 3 cycles later; stale mode keeps the old high
   // for 5 cycles first. Also flags any handshake/direction-setup violation.
   always @(posedge clk) begin
      ps0_q   <= dut_ps[0];
      ps1_q   <= dut_ps[1];
      low_cnt <= dut_ps[0] ? 0 : low_cnt + 1;
      if (dcm_rst) begin
         ps_done  <= 1'b1;
         dcm_cnt  <= 0;
         dcm_hang <= 1'b0;
         tb_pos   <= 0;
         n_inc    <= 0;
         n_dec    <= 0;
         n_req    <= 0;
         viol     <= 0;
         low_cnt  <= 10;
      end else begin
         if (!dcm_hang &&
             ((dut_ps[1] != ps1_q && (dut_ps[0] || ps0_q)) ||
              (rise && (dcm_cnt != 0 || dut_ps[1] != ps1_q || low_cnt < 2)) ||
              (fall && (dcm_cnt != 0 || !ps_done))))
            viol <= viol + 1;
         if (rise) begin
            n_req <= n_req + 1;
            if (dut_ps[1]) begin
               n_inc  <= n_inc + 1;
               tb_pos <= tb_pos + 1;
            end else begin
               n_dec  <= n_dec + 1;
               tb_pos <= tb_pos - 1;
            end
            dcm_cnt <= 1;
            ps_done <= stale;
            if (n_req + 1 == hang_step) dcm_hang <= 1'b1;
         end else if (dcm_cnt != 0) begin
            dcm_cnt <= dcm_cnt + 1;
            if (stale && dcm_cnt == 5) ps_done <= 1'b0;
            if (dcm_cnt == (stale ? 8 : 3)) begin
               dcm_cnt <= 0;
               if (!dcm_hang) ps_done <= 1'b1;
            end
         end
      end
   end

   // Test-read responder; in spur mode it also fires acks while no test is requested
   always @(posedge clk) begin
      if (test_ack) begin
         test_ack  <= 1'b0;
         test_pass <= 1'b0;
      end else if (test_req) begin
         if (ack_cnt == 2) begin
            ack_cnt   <= 0;
            test_ack  <= 1'b1;
            test_pass <= (tb_pos >= win_lo) && (tb_pos <= win_hi);
         end else begin
            ack_cnt <= ack_cnt + 1;
         end
      end else if (spur && dut_ps[0]) begin
         test_ack  <= 1'b1;
         test_pass <= 1'b1;
      end
   end

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic wait_idle(input bit restart, input int budget);
      for (int i = 0; i < budget; i++) begin
         if (!cal_busy) break;
         cal_start = restart && (i == 100);
         @(negedge clk);
      end
      cal_start = 1'b0;
      check("busy_cleared", cal_busy, 0);
   endtask

   task automatic run_vec(input int idx);
      exp_t e;
      win_lo = vecs[idx].lo;
      win_hi = vecs[idx].hi;
      stale = vecs[idx].stale;
      spur = vecs[idx].spur;
      hang_step = 0;
      dcm_rst = 1'b1;
      @(negedge clk);
      dcm_rst = 1'b0;
      e = '{vecs[idx].phase, vecs[idx].window, vecs[idx].done, vecs[idx].error,
            vecs[idx].incs, vecs[idx].decs};
      exp_q.push_back(e);
      cal_start = 1'b1;
      @(negedge clk);
      cal_start = 1'b0;
      check("busy_started", cal_busy, 1);
      wait_idle(vecs[idx].restart, 20000);
      e = exp_q.pop_front();
      $display("vector %0d: phase %0d window %0d done %0d error %0d", idx, cal_phase,
               cal_window, cal_done, cal_error);
      check("cal_phase", int'(cal_phase), e.phase);
      check("cal_window", int'(cal_window), e.window);
      check("cal_done", cal_done, e.done);
      check("cal_error", cal_error, e.error);
      check("increments", n_inc, e.incs);
      check("decrements", n_dec, e.decs);
      check("ps_protocol_violations", viol, 0);
      check("ps_idle", dut_ps, 0);
      check("test_req_idle", test_req, 0);
   endtask

   task automatic start_hang(input int step);
      win_lo = 100;
      win_hi = 100;
      stale = 1'b0;
      spur = 1'b0;
      hang_step = step;
      dcm_rst = 1'b1;
      @(negedge clk);
      dcm_rst = 1'b0;
      cal_start = 1'b1;
      @(negedge clk);
      cal_start = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         if (n_req == step && dut_ps == 2'b11) break;
         @(negedge clk);
      end
      check("hang_step_reached", n_req, step);
   endtask

   initial begin
      //          lo   hi  stl spr rst  phase win done err incs decs
      vecs[0] = '{10,  30,  0,  0,  0,  20,   21,  1,   0,  31,  11};
      vecs[1] = '{100, 100, 0,  1,  0,  0,    0,   0,   1,  40,  40};
      vecs[2] = '{0,   40,  0,  0,  0,  20,   41,  1,   0,  40,  20};
      vecs[3] = '{35,  45,  0,  0,  0,  37,   6,   1,   0,  40,  3};
      vecs[4] = '{0,   0,   0,  0,  0,  0,    1,   1,   0,  1,   1};
      vecs[5] = '{5,   5,   0,  0,  0,  5,    1,   1,   0,  6,   1};
      vecs[6] = '{2,   4,   1,  0,  0,  3,    3,   1,   0,  5,   2};
      vecs[7] = '{2,   9,   0,  0,  1,  5,    8,   1,   0,  10,  5};

      repeat (3) @(negedge clk);
      check("rst_ps", dut_ps, 0);
      check("rst_test_req", test_req, 0);
      check("rst_cal_busy", cal_busy, 0);
      check("rst_cal_done", cal_done, 0);
      check("rst_cal_error", cal_error, 0);
      check("rst_cal_phase", int'(cal_phase), 0);
      check("rst_cal_window", int'(cal_window), 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      for (int v = 0; v < 8; v++) run_vec(v);

      // Step 3 never completes
      start_hang(3);
`ifdef PHASE_CAL_TIMEOUT_EN
      wait_idle(1'b0, 2000);
      check("timeout_ps", dut_ps, 0);
      check("timeout_error", cal_error, 1);
      check("timeout_done", cal_done, 0);
      check("timeout_phase", int'(cal_phase), 2);
      check("timeout_incs", n_inc, 3);
      start_hang(2);
      repeat (10) @(negedge clk);
`else
      repeat (400) @(negedge clk);
      check("hang_busy_held", cal_busy, 1);
      check("hang_ps_held", dut_ps, 3);
      check("hang_incs", n_inc, 3);
`endif
      // Reset while waiting for ps_done to rise takes effect without a clock edge
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_ps", dut_ps, 0);
      check("async_rst_busy", cal_busy, 0);
      check("async_rst_test_req", test_req, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run_vec(0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
